// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: PC-mux select and IF/ID, ID/EX flush/stall sequencing.
// Ports: clk, rst (async, active-high); redirect_valid, redirect_code[1:0],
//   stall_req, resume in; pc_sel[1:0], pc_write, ifid_write, flush_ifid,
//   flush_idex, halted, busy, taken_cnt[CNT_W-1:0] out.
// Build option: define BRANCH_STATS_EN to count taken redirects in taken_cnt.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_code,
  input  logic             stall_req,
  input  logic             resume,
  output logic [1:0]       pc_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_e;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;

  logic sys_req;
  logic tgt_req;

  assign sys_req = redirect_valid && (redirect_code == 2'b11);
  assign tgt_req = redirect_valid &&
                   ((redirect_code == 2'b01) ||
                    (redirect_code == 2'b10));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_sel     = 2'b00;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = 1'b0;
    busy       = 1'b0;
    if (rst) begin
      // Hold the pipeline frozen and empty while reset is applied.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (sys_req) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = S_HALT;
          end else if (tgt_req) begin
            pc_sel     = redirect_code;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            // Redirect cycle counts as the first bubble.
            if (FLUSH_CYCLES > 1) begin
              state_d = S_FLUSH;
              fcnt_d  = FCNT_INIT;
            end
          end else if (stall_req) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_idex = 1'b1;
          end
        end
        S_FLUSH: begin
          // Younger instructions are wrong-path: ignore their requests.
          busy       = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          fcnt_d     = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = S_RUN;
            fcnt_d  = '0;
          end
        end
        S_HALT: begin
          busy       = 1'b1;
          halted     = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          flush_idex = 1'b1;
          if (resume) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign accept = (state_q == S_RUN) && tgt_req;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scenarios plus randomized traffic against
// a cycle-level reference model, on a FLUSH_CYCLES=2 and a FLUSH_CYCLES=4 copy.
module tb_pc_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       redirect_valid = 1'b0;
  logic [1:0] redirect_code = 2'b00;
  logic       stall_req = 1'b0;
  logic       resume = 1'b0;

  logic [1:0]  pc_sel_a, pc_sel_b;
  logic        pc_write_a, pc_write_b;
  logic        ifid_write_a, ifid_write_b;
  logic        flush_ifid_a, flush_ifid_b;
  logic        flush_idex_a, flush_idex_b;
  logic        halted_a, halted_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  // Output vector: pc_sel, pc_write, ifid_write, flush_ifid, flush_idex, halted, busy
  localparam logic [7:0] V_RST   = 8'b00_0011_00;
  localparam logic [7:0] V_IDLE  = 8'b00_1100_00;
  localparam logic [7:0] V_STALL = 8'b00_0001_00;
  localparam logic [7:0] V_FLUSH = 8'b00_1111_01;
  localparam logic [7:0] V_HALT  = 8'b00_0001_11;
  localparam logic [7:0] V_SYS   = 8'b00_0011_00;

  logic [7:0] oa, ob;
  assign oa = {pc_sel_a, pc_write_a, ifid_write_a, flush_ifid_a,
               flush_idex_a, halted_a, busy_a};
  assign ob = {pc_sel_b, pc_write_b, ifid_write_b, flush_ifid_b,
               flush_idex_b, halted_b, busy_b};

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_code(redirect_code),
    .stall_req(stall_req), .resume(resume),
    .pc_sel(pc_sel_a), .pc_write(pc_write_a), .ifid_write(ifid_write_a),
    .flush_ifid(flush_ifid_a), .flush_idex(flush_idex_a),
    .halted(halted_a), .busy(busy_a), .taken_cnt(cnt_a)
  );

  pc_redirect_ctrl #(.FLUSH_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_code(redirect_code),
    .stall_req(stall_req), .resume(resume),
    .pc_sel(pc_sel_b), .pc_write(pc_write_b), .ifid_write(ifid_write_b),
    .flush_ifid(flush_ifid_b), .flush_idex(flush_idex_b),
    .halted(halted_b), .busy(busy_b), .taken_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: halt flag, remaining wrong-path bubbles, redirect tally.
  bit m_halt[2];
  int m_left[2];
  int m_cnt[2];
  int fc_of[2]   = '{2, 4};
  int cmax_of[2] = '{65535, 3};

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_halt[i] = 1'b0;
      m_left[i] = 0;
      m_cnt[i]  = 0;
    end
  endfunction

  function automatic logic [7:0] exp_out(int i);
    if (rst) return V_RST;
    if (m_halt[i]) return V_HALT;
    if (m_left[i] > 0) return V_FLUSH;
    if (redirect_valid && redirect_code == 2'b11) return V_SYS;
    if (redirect_valid && redirect_code != 2'b00)
      return {redirect_code, 6'b1111_00};
    if (stall_req) return V_STALL;
    return V_IDLE;
  endfunction

  function automatic int exp_cnt(int i);
    return rst ? 0 : m_cnt[i];
  endfunction

  function automatic void model_edge(int i);
    if (rst) begin
      m_halt[i] = 1'b0;
      m_left[i] = 0;
      m_cnt[i]  = 0;
    end else if (m_halt[i]) begin
      if (resume) m_halt[i] = 1'b0;
    end else if (m_left[i] > 0) begin
      m_left[i] = m_left[i] - 1;
    end else if (redirect_valid && redirect_code == 2'b11) begin
      m_halt[i] = 1'b1;
    end else if (redirect_valid && redirect_code != 2'b00) begin
      m_left[i] = fc_of[i] - 1;
`ifdef BRANCH_STATS_EN
      if (m_cnt[i] < cmax_of[i]) m_cnt[i] = m_cnt[i] + 1;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    redirect_valid = 1'b0;
    redirect_code  = 2'b00;
    stall_req      = 1'b0;
    resume         = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (oa !== V_RST) begin
        errors++;
        $display("FAIL reset_a cyc%0d got=%b exp=%b", k, oa, V_RST);
      end
      checks++;
      if (ob !== V_RST || cnt_b !== 2'd0) begin
        errors++;
        $display("FAIL reset_b cyc%0d got=%b/%0d exp=%b/0", k, ob, cnt_b, V_RST);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (oa !== V_IDLE || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_release got=%b/%0d exp=%b/0", oa, cnt_a, V_IDLE);
    end
    tick();
  endtask

  task automatic test_redirect();
    idle(4);
    redirect_valid = 1'b1;
    redirect_code  = 2'b01;
    #1;
    checks++;
    if (oa !== 8'b01_1111_00) begin
      errors++;
      $display("FAIL redirect_c0 got=%b exp=%b", oa, 8'b01_1111_00);
    end
    tick();
    redirect_code = 2'b10;
    #1;
    checks++;
    if (oa !== V_FLUSH) begin
      errors++;
      $display("FAIL redirect_c1 got=%b exp=%b", oa, V_FLUSH);
    end
    checks++;
    if (ob !== V_FLUSH) begin
      errors++;
      $display("FAIL redirect_c1_b got=%b exp=%b", ob, V_FLUSH);
    end
    tick();
    redirect_valid = 1'b0;
    redirect_code  = 2'b00;
    #1;
    checks++;
    if (oa !== V_IDLE) begin
      errors++;
      $display("FAIL redirect_c2 got=%b exp=%b", oa, V_IDLE);
    end
    checks++;
    if (ob !== V_FLUSH) begin
      errors++;
      $display("FAIL redirect_c2_b got=%b exp=%b", ob, V_FLUSH);
    end
    tick();
    idle(4);
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      stall_req = 1'b1;
      #1;
      checks++;
      if (oa !== V_STALL) begin
        errors++;
        $display("FAIL stall_c%0d got=%b exp=%b", k, oa, V_STALL);
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_code  = 2'b10;
    #1;
    checks++;
    if (oa !== 8'b10_1111_00) begin
      errors++;
      $display("FAIL stall_vs_redirect got=%b exp=%b", oa, 8'b10_1111_00);
    end
    tick();
    idle(4);
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1;
    redirect_code  = 2'b11;
    stall_req      = 1'b1;
    #1;
    checks++;
    if (oa !== V_SYS) begin
      errors++;
      $display("FAIL halt_enter got=%b exp=%b", oa, V_SYS);
    end
    tick();
    for (int k = 1; k < 5; k++) begin
      redirect_valid = 1'($urandom);
      redirect_code  = 2'($urandom);
      stall_req      = 1'($urandom);
      #1;
      checks++;
      if (oa !== V_HALT || ob !== V_HALT) begin
        errors++;
        $display("FAIL halt_hold +%0d got=%b/%b exp=%b", k, oa, ob, V_HALT);
      end
      tick();
    end
    resume         = 1'b1;
    redirect_valid = 1'b1;
    redirect_code  = 2'b01;
    #1;
    checks++;
    if (oa !== V_HALT) begin
      errors++;
      $display("FAIL halt_resume_cycle got=%b exp=%b", oa, V_HALT);
    end
    tick();
    idle(0);
    #1;
    checks++;
    if (oa !== V_IDLE || ob !== V_IDLE) begin
      errors++;
      $display("FAIL halt_released got=%b/%b exp=%b", oa, ob, V_IDLE);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    idle(4);
    redirect_valid = 1'b1;
    redirect_code  = 2'b01;
    tick();
    redirect_valid = 1'b0;
    redirect_code  = 2'b00;
    #1;
    checks++;
    if (ob !== V_FLUSH) begin
      errors++;
      $display("FAIL midflush_pre got=%b exp=%b", ob, V_FLUSH);
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (ob !== V_RST || cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL midflush_rst got=%b/%0d exp=%b/0", ob, cnt_b, V_RST);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ob !== V_IDLE) begin
      errors++;
      $display("FAIL midflush_release got=%b exp=%b", ob, V_IDLE);
    end
    tick();
  endtask

  task automatic test_stats();
    logic [1:0]  want_b;
    logic [15:0] want_a;
`ifdef BRANCH_STATS_EN
    want_b = 2'd3;
    want_a = 16'd5;
`else
    want_b = 2'd0;
    want_a = 16'd0;
`endif
    rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      redirect_valid = 1'b1;
      redirect_code  = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      idle(4);
    end
    #1;
    checks++;
    if (cnt_b !== want_b) begin
      errors++;
      $display("FAIL stats_sat got=%0d exp=%0d", cnt_b, want_b);
    end
    checks++;
    if (cnt_a !== want_a) begin
      errors++;
      $display("FAIL stats_wide got=%0d exp=%0d", cnt_a, want_a);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst            = ($urandom_range(0, 49) == 0);
      redirect_valid = 1'($urandom);
      redirect_code  = 2'($urandom);
      stall_req      = 1'($urandom);
      resume         = ($urandom_range(0, 3) == 0);
      if (rst) model_clear();
      #1;
      checks++;
      if (oa !== exp_out(0)) begin
        errors++;
        $display("FAIL rand_a cyc%0d got=%b exp=%b", k, oa, exp_out(0));
      end
      checks++;
      if (ob !== exp_out(1)) begin
        errors++;
        $display("FAIL rand_b cyc%0d got=%b exp=%b", k, ob, exp_out(1));
      end
      checks++;
      if (cnt_a !== 16'(exp_cnt(0)) || cnt_b !== 2'(exp_cnt(1))) begin
        errors++;
        $display("FAIL rand_cnt cyc%0d got=%0d/%0d exp=%0d/%0d",
                 k, cnt_a, cnt_b, exp_cnt(0), exp_cnt(1));
      end
      tick();
    end
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_redirect();
    test_stall();
    test_halt();
    test_reset_mid_flush();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
